tlc_timer_sense: RTL and testbench

- Input-conditioning stage that sits directly upstream of the traffic-light controller FSM (`fsm`).
- Produces the FSM's timer inputs TS (short interval expired) and TL (long interval expired) from a restartable prescaled interval counter.
- Produces the FSM's side-street car input C from a synchronised, debounced raw sensor line.
- The FSM pulses ST on every state change to restart timing. TS/TL/C feed the FSM's TS/TL/C ports directly.

---
 rtl/tlc_pkg.sv | 20 ++
 rtl/car_debounce.sv | 54 +++++
 rtl/tlc_timer_sense.sv | 74 +++++++
 tb/tb_tlc_timer_sense.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared timing constants for the traffic-light controller slice.
// Used by the input-conditioning stage now and by the FSM/top level later.
package tlc_pkg;

    localparam int unsigned TS_TICKS_DEF   = 3;
    localparam int unsigned TL_TICKS_DEF   = 8;
    localparam int unsigned PRESCALE_SIM   = 2;
    localparam int unsigned PRESCALE_BOARD = 50_000_000;  // 1 s ticks at 50 MHz
    localparam int unsigned DEB_CYCLES_DEF = 4;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PRE_W_DEF = 26;
    localparam int unsigned DEB_W_DEF = 8;

    typedef struct packed {
        logic ts;
        logic tl;
    } timer_flags_t;

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchroniser followed by a stable-sample debounce counter.
// dout follows the synchronised input only after DEB_CYCLES consecutive differing samples.
module car_debounce
    import tlc_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             c_q, c_d;

    always_comb begin
        sync1_d   = din;
        sync2_d   = sync1_q;
        deb_cnt_d = deb_cnt_q;
        c_d       = c_q;
        // Any return to the current output level discards a partial count.
        if (sync2_q == c_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            c_d       = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            c_q       <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            c_q       <= c_d;
        end
    end

    assign dout = c_q;

endmodule

// File: rtl/tlc_timer_sense.sv
// Timer and car-sensor conditioning for the traffic-light FSM.
// TS/TL decode a restartable, saturating prescaled tick count; C is the debounced sensor.
module tlc_timer_sense
    import tlc_pkg::*;
#(
    parameter int unsigned PRESCALE   = PRESCALE_SIM,
    parameter int unsigned TS_TICKS   = TS_TICKS_DEF,
    parameter int unsigned TL_TICKS   = TL_TICKS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned PRE_W      = PRE_W_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ST,
    input  logic C_in,
    output logic TS,
    output logic TL,
    output logic C
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] TS_CNT   = CNT_W'(TS_TICKS);
    localparam logic [CNT_W-1:0] TL_CNT   = CNT_W'(TL_TICKS);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    timer_flags_t     flags;

    always_comb begin
        pre_cnt_d  = pre_cnt_q + PRE_W'(1);
        tick_cnt_d = tick_cnt_q;
        if (ST) begin
            pre_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
            // Saturate at TL so the outputs hold until the next restart.
            if (tick_cnt_q != TL_CNT) begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        flags.ts = (tick_cnt_q >= TS_CNT);
        flags.tl = (tick_cnt_q >= TL_CNT);
    end

    assign TS = flags.ts;
    assign TL = flags.tl;

    car_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_car_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (C_in),
        .dout (C)
    );

endmodule

// File: tb/tb_tlc_timer_sense.sv
// Scenario bench for tlc_timer_sense at default parameters.
// Expected {TS,TL,C} per edge is queued before the edge and popped after it.
module tb_tlc_timer_sense;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ST = 1'b1;
    logic C_in = 1'b1;
    logic TS, TL, C;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] sb_q[$];
    logic [2:0] got, exp_v;

    tlc_timer_sense #(
        .PRESCALE  (2),
        .TS_TICKS  (3),
        .TL_TICKS  (8),
        .CNT_W     (8),
        .PRE_W     (26),
        .DEB_CYCLES(4),
        .DEB_W     (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ST   (ST),
        .C_in (C_in),
        .TS   (TS),
        .TL   (TL),
        .C    (C)
    );

    always #5 clk = ~clk;

    // Reset held 3 edges with ST=1, C_in=1, then released with C_in still high.
    task automatic test_reset();
        for (int j = 1; j <= 23; j++) begin
            int k;
            k = j - 3;
            reset = (j <= 3);
            ST    = (j <= 3);
            C_in  = 1'b1;
            if (j <= 3) sb_q.push_back(3'b000);
            else        sb_q.push_back({k >= 6, k >= 16, k >= 6});
            @(posedge clk); #1;
            got = {TS, TL, C};
            exp_v = sb_q.pop_front();
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset edge %0d: TS/TL/C got %b expected %b", j, got, exp_v);
            end
        end
    endtask

    // ST held high throughout, so TS/TL must stay 0 while C is exercised.
    task automatic test_debounce();
        int ph_len[5] = '{10, 12, 10, 12, 8};
        for (int ph = 0; ph < 5; ph++) begin
            for (int j = 1; j <= ph_len[ph]; j++) begin
                logic ec;
                ST = 1'b1;
                case (ph)
                    0: begin C_in = 1'b0;      ec = (j < 6);  end  // falling edge, held
                    1: begin C_in = (j <= 3);  ec = 1'b0;     end  // 3-cycle glitch rejected
                    2: begin C_in = 1'b1;      ec = (j >= 6); end  // rising edge, held
                    3: begin C_in = (j > 2);   ec = 1'b1;     end  // 2-cycle dropout rejected
                    default: begin C_in = 1'b0; ec = (j < 6); end
                endcase
                sb_q.push_back({1'b0, 1'b0, ec});
                @(posedge clk); #1;
                got = {TS, TL, C};
                exp_v = sb_q.pop_front();
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL debounce phase %0d edge %0d: TS/TL/C got %b expected %b",
                             ph, j, got, exp_v);
                end
            end
        end
    endtask

    // Single-cycle ST at edge 0, then free-run well past saturation.
    task automatic test_single_st();
        for (int j = 0; j <= 56; j++) begin
            ST   = (j == 0);
            C_in = 1'b0;
            sb_q.push_back({j >= 6, j >= 16, 1'b0});
            @(posedge clk); #1;
            got = {TS, TL, C};
            exp_v = sb_q.pop_front();
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL single_st edge %0d: TS/TL/C got %b expected %b", j, got, exp_v);
            end
        end
    endtask

    // Restart while TS is already high.
    task automatic test_restart();
        for (int j = 0; j <= 30; j++) begin
            int k;
            k = (j >= 10) ? j - 10 : j;
            ST   = (j == 0) || (j == 10);
            C_in = 1'b0;
            sb_q.push_back({k >= 6, k >= 16, 1'b0});
            @(posedge clk); #1;
            got = {TS, TL, C};
            exp_v = sb_q.pop_front();
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL restart edge %0d: TS/TL/C got %b expected %b", j, got, exp_v);
            end
        end
    endtask

    // ST held for 10 edges (0..9), then released.
    task automatic test_st_held();
        for (int j = 0; j <= 20; j++) begin
            int k;
            k = j - 9;
            ST   = (j <= 9);
            C_in = 1'b0;
            sb_q.push_back({k >= 6, k >= 16, 1'b0});
            @(posedge clk); #1;
            got = {TS, TL, C};
            exp_v = sb_q.pop_front();
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL st_held edge %0d: TS/TL/C got %b expected %b", j, got, exp_v);
            end
        end
    endtask

    // Reset for one edge (19) while TL=1 and the debounce count is part-way.
    task automatic test_reset_midcount();
        for (int j = 0; j <= 29; j++) begin
            int k;
            k = j - 19;
            ST    = (j == 0);
            C_in  = (j >= 15);
            reset = (j == 19);
            if (j < 19)       sb_q.push_back({j >= 6, j >= 16, 1'b0});
            else if (j == 19) sb_q.push_back(3'b000);
            else              sb_q.push_back({k >= 6, k >= 16, k >= 6});
            @(posedge clk); #1;
            got = {TS, TL, C};
            exp_v = sb_q.pop_front();
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset_midcount edge %0d: TS/TL/C got %b expected %b",
                         j, got, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_single_st();
        test_restart();
        test_st_held();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
